// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: DEPTH-entry FIFO of {pc, inst} between fetch and decode.
// Head appears one cycle after push (no bypass); rdy=0 freezes everything, flush empties it.
module if_id_queue #(
  parameter int                ADDR_W      = 32,
  parameter int                INST_W      = 32,
  parameter int                DEPTH       = 4,
  parameter logic [INST_W-1:0] BUBBLE_INST = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic                         if_valid,
  input  logic [ADDR_W-1:0]            if_pc,
  input  logic [INST_W-1:0]            if_inst,
  output logic                         if_ready,
  input  logic                         id_stall,
  output logic                         id_valid,
  output logic [ADDR_W-1:0]            id_pc,
  output logic [INST_W-1:0]            id_inst,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  // Outputs depend on registered state only, so there is no input-to-output path.
  assign if_ready = (count_q != FULL_CNT);
  assign id_valid = (count_q != '0);
  assign id_pc    = id_valid ? mem_q[rptr_q].pc   : '0;
  assign id_inst  = id_valid ? mem_q[rptr_q].inst : BUBBLE_INST;
  assign count    = count_q;

  assign push = if_valid && if_ready && rdy && !flush;
  assign pop  = id_valid && !id_stall && rdy && !flush;

  always_comb begin
    mem_d   = mem_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (rst || (rdy && flush)) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = '{pc: if_pc, inst: if_inst};
        wptr_d        = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q   <= mem_d;
    rptr_q  <= rptr_d;
    wptr_q  <= wptr_d;
    count_q <= count_d;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: stimulus queues expected heads, a negedge monitor checks each pop.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, if_valid, id_stall;
  logic [31:0] if_pc, if_inst;
  logic        if_ready, id_valid;
  logic [31:0] id_pc, id_inst;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q [$];

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .BUBBLE_INST(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .id_stall(id_stall), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h1300_0013 ^ pc;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one fetch for the next edge; the scoreboard only learns about it when it should be accepted.
  task automatic offer(input logic [31:0] pc, input bit accepted);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst_of(pc);
    if (accepted) exp_q.push_back('{pc: pc, inst: inst_of(pc)});
  endtask

  // Monitor: a pop happens at the coming edge whenever these conditions hold now.
  always @(negedge clk) begin
    if (rst === 1'b0 && rdy && !flush && !id_stall && id_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %0h expected no entry", id_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pop_pc", 64'(id_pc), 64'(e.pc));
        chk("pop_inst", 64'(id_inst), 64'(e.inst));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; id_stall = 1'b0;
    if_valid = 1'b1; if_pc = 32'h100; if_inst = inst_of(32'h100);
    tick(); tick();
    rst = 1'b0; if_valid = 1'b0;
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_id_pc", 64'(id_pc), 64'd0);
    chk("rst_id_inst", 64'(id_inst), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd1);

    // Fill to full with the decoder stalled, then offer one more.
    id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(32'(4 * i), 1'b1);
      tick();
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_if_ready", 64'(if_ready), 64'd0);
    offer(32'h10, 1'b0);
    tick();
    chk("full_reject_count", 64'(count), 64'd4);
    if_valid = 1'b0;
    id_stall = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("drain_id_valid", 64'(id_valid), 64'd0);
    chk("drain_id_pc", 64'(id_pc), 64'd0);
    chk("drain_count", 64'(count), 64'd0);

    // Streaming: push and pop every cycle across several pointer wraps.
    for (int i = 0; i < 16; i++) begin
      offer(32'(4 * i), 1'b1);
      tick();
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_head", 64'(id_pc), 64'(4 * i));
    end
    if_valid = 1'b0;
    tick();
    chk("stream_end_count", 64'(count), 64'd0);

    // Flush with three entries queued and a concurrent fetch.
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(32'h40 + 32'(4 * i), 1'b1);
      tick();
    end
    chk("preflush_count", 64'(count), 64'd3);
    offer(32'h200, 1'b0);
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_id_valid", 64'(id_valid), 64'd0);
    chk("flush_id_inst", 64'(id_inst), 64'd0);
    chk("flush_if_ready", 64'(if_ready), 64'd1);
    offer(32'h300, 1'b1);
    tick();
    if_valid = 1'b0;
    chk("postflush_head_valid", 64'(id_valid), 64'd1);
    chk("postflush_head_pc", 64'(id_pc), 64'h300);
    id_stall = 1'b0;
    tick();
    chk("postflush_count", 64'(count), 64'd0);

    // rdy freeze: flush, fetch and pop all held off while rdy is low.
    id_stall = 1'b1;
    offer(32'h500, 1'b1); tick();
    offer(32'h504, 1'b1); tick();
    rdy = 1'b0; flush = 1'b1; id_stall = 1'b0;
    offer(32'h600, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("freeze_count", 64'(count), 64'd2);
      chk("freeze_id_pc", 64'(id_pc), 64'h500);
    end
    rdy = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0; if_valid = 1'b0;
    chk("unfreeze_flush_count", 64'(count), 64'd0);
    chk("unfreeze_id_valid", 64'(id_valid), 64'd0);

    // Full plus pop: push rejected while full, accepted the cycle after.
    id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(32'h700 + 32'(4 * i), 1'b1);
      tick();
    end
    chk("fp_full_count", 64'(count), 64'd4);
    id_stall = 1'b0;
    offer(32'h710, 1'b0);
    tick();
    chk("fp_count_after_pop", 64'(count), 64'd3);
    chk("fp_if_ready", 64'(if_ready), 64'd1);
    offer(32'h710, 1'b1);
    tick();
    chk("fp_count_push_pop", 64'(count), 64'd3);
    if_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("fp_drain_count", 64'(count), 64'd0);
    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised IF→ID decoupling stage.
- Replaces the single-entry IF/ID pipeline latch with a DEPTH-entry instruction queue.
- Handles valid/ready handshake on the fetch side, stall on the decode side, and a jump flush that squashes everything queued.
- Sits between the fetch unit and the decoder; exposes occupancy for the fetch prefetch logic.

Parameters:
- ADDR_W, 32, width of pc fields.
- INST_W, 32, width of instruction fields.
- DEPTH, 4, queue entries; power of two, >= 2.
- BUBBLE_INST, 0, value driven on id_inst when no valid entry (all-zero word).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global ready; when 0 the block holds all state.
- flush  in  1  jump taken; squash all queued entries.
- if_valid  in  1  fetch presents an instruction this cycle.
- if_pc  in  ADDR_W  pc of fetched instruction.
- if_inst  in  INST_W  fetched instruction.
- if_ready  out  1  queue can accept; equals (count < DEPTH).
- id_stall  in  1  decoder cannot consume this cycle.
- id_valid  out  1  head entry valid; equals (count != 0).
- id_pc  out  ADDR_W  head pc; 0 when !id_valid.
- id_inst  out  INST_W  head instruction; BUBBLE_INST when !id_valid.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Behaviour:
- State:
  - Storage array of DEPTH {pc, inst} entries.
  - rptr and wptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
- Outputs if_ready, id_valid, id_pc, id_inst are combinational from registered state only; no input→output combinational path.
- Reset (rst=1 at edge): rptr=0, wptr=0, count=0. Next cycle id_valid=0, id_pc=0, id_inst=BUBBLE_INST, if_ready=1. rst overrides rdy, flush and all handshakes. Storage contents need not be cleared.
- rdy=0: no pointer, count or storage change, including flush, push and pop. Upstream holds flush until rdy=1.
- Push: if_valid && if_ready && rdy && !flush.
  - Write {if_pc, if_inst} at wptr.
  - wptr+1 with wrap.
- Pop: id_valid && !id_stall && rdy && !flush.
  - rptr+1 with wrap.
- Count update when neither flush nor rst: count + push − pop.
  - Simultaneous push and pop leave count unchanged.
- Latency: an entry pushed into an empty queue appears on id_* the following cycle. There is no same-cycle bypass.
- Full (count==DEPTH): if_ready=0 and the push is ignored, even if a pop occurs in the same cycle. No pass-through when full.
- Empty (count==0): id_valid=0 and outputs show the bubble (0 / BUBBLE_INST). id_stall has no effect.
- Flush (flush && rdy): next cycle rptr=wptr=0 and count=0. Flush has priority over push and pop in the same cycle; a concurrent fetch is discarded. The following cycle presents the bubble on id_* and if_ready=1.
- Wrap-around: pointers roll DEPTH−1 → 0. FIFO ordering is preserved across the wrap.
- Reset mid-operation discards all entries, identical to power-on reset.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with if_valid=1, if_pc=0x100.
  - Required response: after release id_valid=0, id_pc=0, id_inst=0, count=0, if_ready=1. The queued fetch is not stored.
- Fill to full (DEPTH=4, id_stall=1):
  - Stimulus: push pc 0x0,0x4,0x8,0xC, then offer 0x10.
  - Required response: count=4, if_ready=0, 0x10 rejected. After id_stall=0, id_pc sequence is 0x0,0x4,0x8,0xC, then bubble.
- Streaming with wrap:
  - Stimulus: continuous if_valid with pcs 0x0..0x3C step 4, id_stall=0.
  - Required response: count stays 1 after the first push. id_pc follows if_pc with one cycle latency for all 16 instructions across multiple pointer wraps.
- Flush:
  - Stimulus: queue holds 3 entries; assert flush with if_valid=1, if_pc=0x200.
  - Required response: next cycle count=0, id_valid=0, id_inst=0. Entry 0x200 is absent. A push of 0x300 the following cycle appears as the head one cycle later.
- rdy freeze:
  - Stimulus: queue holds 2 entries; hold rdy=0 for 3 cycles with flush=1, if_valid=1, id_stall=0.
  - Required response: count stays 2 and id_pc unchanged throughout. Flush takes effect on the first cycle after rdy returns to 1.
- Full plus pop:
  - Stimulus: count=4, id_stall=0, if_valid=1.
  - Required response: the pop occurs, the push is rejected, and count becomes 3. On the next cycle if_ready=1 and the push succeeds.
